// File: rtl/tile_ram_arbiter_pkg.sv
// Shared tile-map constants, tile address helper and response pipeline type
// for the tile RAM arbiter.
package tile_ram_arbiter_pkg;

  localparam int TILE_SIZE     = 20;
  localparam int COLS          = 32;
  localparam int ROWS          = 24;
  localparam int N_TILES       = COLS * ROWS;
  localparam int TILE_WALL_BIT = 0;
  localparam int TILE_BEAN_BIT = 1;

  // Off-map tiles read back as solid wall so movers never walk off the board.
  localparam logic [1:0] TILE_OOB = 2'b01;

  typedef struct packed {
    logic is_read;
    logic oob;
  } pend_t;

  function automatic logic [9:0] tile_addr(input logic [9:0] x, input logic [8:0] y);
    return 10'(COLS * (int'(y) / TILE_SIZE) + int'(x) / TILE_SIZE);
  endfunction

endpackage

// File: rtl/tile_ram_arbiter_if.sv
// Requester-side bus of the tile RAM arbiter: request/grant/response handshake.
interface tile_ram_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 2
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;

  modport master (output req, req_we, req_addr, req_wdata,
                  input  gnt, rsp_valid, rsp_data);
  modport slave  (input  req, req_we, req_addr, req_wdata,
                  output gnt, rsp_valid, rsp_data);
endinterface

// File: rtl/tile_ram_arbiter_rr_arbiter.sv
// Combinational N-way round-robin pick: first request at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_req[(int'(i_ptr) + k) % N]) begin
        o_any = 1'b1;
        o_idx = PTR_W'((int'(i_ptr) + k) % N);
        o_gnt[(int'(i_ptr) + k) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_ram_arbiter.sv
// Single-port tile RAM arbiter: round-robin grant, RAM drive, 1-cycle response routing.
// Optional build macro PLAYER_PRIORITY_EN gives requester 0 absolute priority.
module tile_ram_arbiter
  import tile_ram_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int COLS   = 32,
  parameter int ROWS   = 24,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  tile_ram_arbiter_if.slave bus,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TILES_L = COLS * ROWS;

  logic [PTR_W-1:0] r_rr_ptr;
  logic             r_vld;
  logic [PTR_W-1:0] r_id;
  pend_t            r_pend;

  logic [N_REQ-1:0]  w_arb_req, w_rr_gnt, w_gnt_raw;
  logic [PTR_W-1:0]  w_rr_idx, w_idx, w_ptr_nxt;
  logic              w_rr_any, w_any_raw, w_any, w_adv, w_oob;
  logic [ADDR_W-1:0] w_addr;

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rr (
    .i_req (w_arb_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_rr_gnt),
    .o_idx (w_rr_idx),
    .o_any (w_rr_any)
  );

`ifdef PLAYER_PRIORITY_EN
  // Player bypasses the ring; ghosts rotate among themselves untouched by player wins.
  assign w_arb_req = bus.req & {{(N_REQ-1){1'b1}}, 1'b0};
  always_comb begin
    w_gnt_raw = w_rr_gnt;
    w_idx     = w_rr_idx;
    w_any_raw = w_rr_any;
    w_adv     = w_rr_any;
    if (bus.req[0]) begin
      w_gnt_raw = {{(N_REQ-1){1'b0}}, 1'b1};
      w_idx     = '0;
      w_any_raw = 1'b1;
      w_adv     = 1'b0;
    end
  end
`else
  assign w_arb_req = bus.req;
  assign w_gnt_raw = w_rr_gnt;
  assign w_idx     = w_rr_idx;
  assign w_any_raw = w_rr_any;
  assign w_adv     = w_rr_any;
`endif

  // Grants are masked while reset is held so nothing reaches the RAM.
  assign bus.gnt = reset ? w_gnt_raw : '0;
  assign w_any   = reset & w_any_raw;

  assign w_addr      = bus.req_addr[w_idx*ADDR_W +: ADDR_W];
  assign w_oob       = int'(w_addr) >= TILES_L;
  assign o_ram_en    = w_any & ~w_oob;
  assign o_ram_we    = o_ram_en & bus.req_we[w_idx];
  assign o_ram_addr  = w_addr;
  assign o_ram_wdata = bus.req_wdata[w_idx*DATA_W +: DATA_W];
  assign w_ptr_nxt   = (w_idx == PTR_W'(N_REQ-1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
      r_vld    <= 1'b0;
      r_id     <= '0;
      r_pend   <= '0;
    end else begin
      r_vld          <= w_any;
      r_id           <= w_idx;
      r_pend.is_read <= ~bus.req_we[w_idx];
      r_pend.oob     <= w_oob;
      if (w_adv) r_rr_ptr <= w_ptr_nxt;
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    if (r_vld) begin
      bus.rsp_valid[r_id] = 1'b1;
      if (r_pend.is_read) bus.rsp_data = r_pend.oob ? DATA_W'(TILE_OOB) : i_ram_rdata;
    end
  end

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Directed bench for tile_ram_arbiter with a write-first 1-cycle RAM model.
module tb_tile_ram_arbiter;
  import tile_ram_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tile_ram_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();

  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  tile_ram_arbiter #(.N_REQ(N), .COLS(32), .ROWS(24), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_ram_en    (ram_en),
    .o_ram_we    (ram_we),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata)
  );

  // Write-first single-port RAM, contents preset to the low address bits.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_we ? ram_wdata : mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input int addr, input logic [1:0] wd);
    bus.req[i] = 1'b1;
    bus.req_we[i] = we;
    bus.req_addr[i*AW +: AW] = AW'(addr);
    bus.req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic clr();
    bus.req = '0;
    bus.req_we = '0;
  endtask

  task automatic chk_rsp(input string tag, input logic [3:0] v, input logic [1:0] d);
    check({tag, "_rv"}, 32'(bus.rsp_valid), 32'(v));
    check({tag, "_rd"}, 32'(bus.rsp_data), 32'(d));
  endtask

  logic [3:0] exp_g [5];
  logic [1:0] exp_d [5];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 2'(i);
    clr();
    bus.req_addr = '0;
    bus.req_wdata = '0;

    // Reset: requests present but nothing granted or strobed
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3, 2'b11);
    #1;
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_en", 32'(ram_en), 0);
    check("rst_we", 32'(ram_we), 0);
    chk_rsp("rst", 4'b0000, 2'b00);
    @(negedge clk);
    clr();
    reset = 1'b1;

`ifndef PLAYER_PRIORITY_EN
    // All four read: rotate 0,1,2,3,0; data = mem[10+i] = 2,3,0,1
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 10 + i, 2'b00);
      #1;
      check("rr_gnt", 32'(bus.gnt), 32'(exp_g[k]));
      if (k == 0) begin
        check("rr_en", 32'(ram_en), 1);
        check("rr_addr", 32'(ram_addr), 10);
      end else chk_rsp("rr", exp_g[k-1], exp_d[k-1]);
    end
    @(negedge clk); clr(); #1;
    check("rr_idle_gnt", 32'(bus.gnt), 0);
    chk_rsp("rr_last", 4'b0001, 2'd2);
`else
    // Player holds priority for 4 cycles, then ghosts rotate 1,2,3
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 10 + i, 2'b00);
      #1;
      check("pp_gnt", 32'(bus.gnt), 32'(4'b0001));
      if (k > 0) chk_rsp("pp", 4'b0001, 2'd2);
    end
    exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.req[0] = 1'b0;
      #1;
      check("pp_ghost_gnt", 32'(bus.gnt), 32'(exp_g[k]));
    end
    @(negedge clk); clr(); #1;
    chk_rsp("pp_last", 4'b1000, 2'd1);
`endif

    // Write 37 <= 2'b10 by req 2, then read back by req 1
    @(negedge clk);
    set_req(2, 1'b1, 37, 2'b10);
    #1;
    check("wr_gnt", 32'(bus.gnt), 32'(4'b0100));
    check("wr_en", 32'(ram_en), 1);
    check("wr_we", 32'(ram_we), 1);
    check("wr_addr", 32'(ram_addr), 37);
    check("wr_wdata", 32'(ram_wdata), 32'(2'b10));
    @(negedge clk); clr();
    set_req(1, 1'b0, 37, 2'b00);
    #1;
    check("rd_gnt", 32'(bus.gnt), 32'(4'b0010));
    chk_rsp("wr_ack", 4'b0100, 2'b00);
    @(negedge clk); clr(); #1;
    chk_rsp("rd_back", 4'b0010, 2'b10);

    // Out-of-range read then write at 800
    @(negedge clk);
    set_req(3, 1'b0, 800, 2'b00);
    #1;
    check("oob_gnt", 32'(bus.gnt), 32'(4'b1000));
    check("oob_en", 32'(ram_en), 0);
    @(negedge clk);
    set_req(3, 1'b1, 800, 2'b11);
    #1;
    check("oobw_gnt", 32'(bus.gnt), 32'(4'b1000));
    check("oobw_en", 32'(ram_en), 0);
    check("oobw_we", 32'(ram_we), 0);
    chk_rsp("oob_rd", 4'b1000, 2'b01);
    @(negedge clk); clr(); #1;
    chk_rsp("oob_wack", 4'b1000, 2'b00);
    check("oob_mem", 32'(mem[800]), 0);

`ifndef PLAYER_PRIORITY_EN
    // req[1] pulsed while req[0] wins; pointer lands on 1
    @(negedge clk);
    set_req(0, 1'b0, 4, 2'b00);
    set_req(1, 1'b0, 5, 2'b00);
    #1;
    check("wd_gnt", 32'(bus.gnt), 32'(4'b0001));
    @(negedge clk); clr(); #1;
    check("wd_gnt_idle", 32'(bus.gnt), 0);
    chk_rsp("wd_rsp", 4'b0001, 2'd0);
    @(negedge clk); #1;
    chk_rsp("wd_none", 4'b0000, 2'd0);
    set_req(0, 1'b0, 4, 2'b00);
    set_req(3, 1'b0, 6, 2'b00);
    #1;
    check("wd_ptr1", 32'(bus.gnt), 32'(4'b1000));
    @(negedge clk); clr(); #1;
    chk_rsp("wd_rsp3", 4'b1000, 2'd2);
`endif

    // Grant to 2, reset next cycle: response discarded, ptr back to 0
    @(negedge clk);
    set_req(2, 1'b0, 5, 2'b00);
    #1;
    check("mr_gnt", 32'(bus.gnt), 32'(4'b0100));
    @(negedge clk);
    clr();
    reset = 1'b0;
    #1;
    chk_rsp("mr_in_rst", 4'b0000, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    set_req(2, 1'b0, 5, 2'b00);
    set_req(3, 1'b0, 6, 2'b00);
    #1;
    chk_rsp("mr_release", 4'b0000, 2'b00);
    check("mr_first_gnt", 32'(bus.gnt), 32'(4'b0100));
    @(negedge clk); clr(); #1;
    chk_rsp("mr_rsp", 4'b0100, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
